// File: rtl/pack_stream_if.sv
// Bus bundle between the source-side AXI-Stream ports, the packer-facing register slice and
// the grant status of pack_stream_arbiter.
interface pack_stream_if #(
  parameter int unsigned N       = 10,
  parameter int unsigned NUM_SRC = 4
);
  localparam int unsigned BW = 8 * N;

  logic [NUM_SRC*BW-1:0] s_tdata;
  logic [NUM_SRC*N-1:0]  s_tkeep;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tready;
  logic [BW-1:0]         m_tdata;
  logic [N-1:0]          m_tkeep;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [NUM_SRC-1:0]    grant;
  logic                  busy;

  // Arbiter side
  modport master (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, grant, busy
  );

  // Environment side: sources plus the downstream packer
  modport slave (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid, grant, busy
  );
endinterface

// File: rtl/pack_stream_arbiter.sv
// Round-robin burst arbiter sharing one byte packer between NUM_SRC AXI-Stream sources,
// with a single output register slice towards the packer.
module pack_stream_arbiter #(
  parameter int unsigned N         = 10,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  pack_stream_if.master bus
);
  localparam int unsigned BW = 8 * N;
  localparam int unsigned SW = $clog2(NUM_SRC);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SW-1:0]      gidx_q, gidx_d;
  logic [SW-1:0]      last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      data_q, data_d;
  logic [N-1:0]       keep_q, keep_d;
  logic               tlast_q, tlast_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [SW-1:0]      sel, cand;
  logic               sel_found;
  logic [BW-1:0]      beat_data;
  logic [N-1:0]       beat_keep;
  logic               beat_last, beat_valid;
  logic               take_c, accept_c, load_c, release_c;

  // Round-robin pick: first valid source after the previous grant, wrapping at NUM_SRC
  always_comb begin
    sel       = '0;
    cand      = '0;
    sel_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = SW'((32'(last_q) + i) % NUM_SRC);
      if (!sel_found && bus.s_tvalid[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign beat_data  = bus.s_tdata[32'(gidx_q) * BW +: BW];
  assign beat_keep  = bus.s_tkeep[32'(gidx_q) * N +: N];
  assign beat_last  = bus.s_tlast[gidx_q];
  assign beat_valid = bus.s_tvalid[gidx_q];

  assign take_c    = (state_q == GRANT) && (!valid_q || bus.m_tready);
  assign accept_c  = take_c && beat_valid;
  // An empty, non-final beat is swallowed: it advances the burst but never reaches the packer
  assign load_c    = accept_c && !((beat_keep == '0) && !beat_last);
  assign release_c = accept_c && (beat_last || (cnt_q == CNT_LAST));

  assign bus.s_tready = take_c ? grant_q : '0;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    tlast_d = tlast_q;
    valid_d = valid_q && !bus.m_tready;

    if (load_c) begin
      data_d  = beat_data;
      keep_d  = beat_keep;
      tlast_d = beat_last;
      valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = GRANT;
          grant_d = NUM_SRC'(1) << sel;
          gidx_d  = sel;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (accept_c) cnt_d = cnt_q + CW'(1);
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= SW'(NUM_SRC - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      tlast_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      tlast_q <= tlast_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.m_tdata  = data_q;
  assign bus.m_tkeep  = keep_q;
  assign bus.m_tlast  = tlast_q;
  assign bus.m_tvalid = valid_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_pack_stream_arbiter.sv
// Scoreboard bench for pack_stream_arbiter: per-source beat queues feed the DUT while a
// transaction-level round-robin model predicts the grant order and the forwarded beats.
module tb_pack_stream_arbiter;
  localparam int unsigned N         = 10;
  localparam int unsigned NUM_SRC   = 4;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned BW        = 8 * N;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [N-1:0]  keep;
    logic          last;
  } beat_t;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  pack_stream_if #(.N(N), .NUM_SRC(NUM_SRC)) bus ();

  pack_stream_arbiter #(.N(N), .NUM_SRC(NUM_SRC), .MAX_BEATS(MAX_BEATS)) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  beat_t stage[NUM_SRC][$];
  beat_t src_q[NUM_SRC][$];
  beat_t exp_q[$];
  int    exp_grant_q[$];
  int    out_cyc[$];
  int    model_last = NUM_SRC - 1;
  int    ready_mode = 1;
  bit    gap_en     = 1'b0;
  logic [NUM_SRC-1:0] acc = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic beat_t rand_beat(input bit allow_zero, input bit last);
    beat_t b;
    b.data = BW'({$urandom, $urandom, $urandom});
    b.keep = (allow_zero && ($urandom_range(5) == 0)) ? '0 : N'($urandom_range(1, (1 << N) - 1));
    b.last = last;
    return b;
  endfunction

  task automatic add_packet(input int k, input int len, input bit allow_zero);
    for (int j = 0; j < len; j++) stage[k].push_back(rand_beat(allow_zero, j == len - 1));
  endtask

  // Hand staged streams to the drivers and predict the result: round-robin over non-empty
  // sources, each burst ending on tlast or after MAX_BEATS beats, empty non-final beats dropped.
  task automatic commit();
    int    g, cnt;
    bit    found;
    beat_t b;
    for (int k = 0; k < NUM_SRC; k++) src_q[k] = stage[k];
    forever begin
      found = 1'b0;
      g     = 0;
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (!found && stage[(model_last + i) % NUM_SRC].size() != 0) begin
          found = 1'b1;
          g     = (model_last + i) % NUM_SRC;
        end
      end
      if (!found) break;
      exp_grant_q.push_back(g);
      cnt = 0;
      do begin
        b = stage[g].pop_front();
        cnt++;
        if (b.keep != '0 || b.last) exp_q.push_back(b);
      end while (!(b.last || cnt == MAX_BEATS));
      model_last = g;
    end
  endtask

  task automatic flush_model();
    for (int k = 0; k < NUM_SRC; k++) begin
      src_q[k].delete();
      stage[k].delete();
    end
    exp_q.delete();
    exp_grant_q.delete();
    model_last = NUM_SRC - 1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    flush_model();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      done = (exp_q.size() == 0);
      for (int k = 0; k < NUM_SRC; k++) if (src_q[k].size() != 0) done = 1'b0;
      if (!done) @(negedge aclk);
    end
    check({name, "_drained"}, done, 1'b1);
    repeat (3) @(negedge aclk);
    check({name, "_grants_seen"}, exp_grant_q.size(), 0);
  endtask

  // Source and packer driver: one beat per source exposed at a time, popped on handshake
  initial begin
    beat_t b;
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = '0;
    bus.s_tvalid = '0;
    bus.m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (acc[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        if (src_q[k].size() != 0) begin
          b = src_q[k][0];
          bus.s_tdata[k*BW +: BW] = b.data;
          bus.s_tkeep[k*N +: N]   = b.keep;
          bus.s_tlast[k]          = b.last;
          bus.s_tvalid[k]         = !(gap_en && bus.grant[k] && ($urandom_range(3) == 0));
        end else begin
          bus.s_tdata[k*BW +: BW] = '0;
          bus.s_tkeep[k*N +: N]   = '0;
          bus.s_tlast[k]          = 1'b0;
          bus.s_tvalid[k]         = 1'b0;
        end
      end
      case (ready_mode)
        0:       bus.m_tready = 1'($urandom_range(1));
        1:       bus.m_tready = 1'b1;
        2:       bus.m_tready = 1'b0;
        default: bus.m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
    end
  end

  // Monitor: scoreboard pops on every output handshake, grant order, stall stability
  initial begin
    logic [NUM_SRC-1:0] prev_grant = '0;
    bit                 prev_stall = 1'b0;
    logic [BW+N:0]      prev_beat  = '0;
    beat_t              e;
    int                 g;
    forever begin
      @(negedge aclk);
      acc = bus.s_tvalid & bus.s_tready;
      if (aresetn) begin
        check("s_tready_at_most_one", $countones(bus.s_tready) <= 1, 1'b1);
        if (prev_stall) begin
          check("stall_m_tvalid_held", bus.m_tvalid, 1'b1);
          check("stall_m_beat_held", {bus.m_tdata, bus.m_tkeep, bus.m_tlast}, prev_beat);
        end
        if (bus.m_tvalid && bus.m_tready) begin
          out_cyc.push_back(cyc);
          check("beat_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("m_tdata", bus.m_tdata, e.data);
            check("m_tkeep", bus.m_tkeep, e.keep);
            check("m_tlast", bus.m_tlast, e.last);
          end
        end
        if (bus.grant != '0 && prev_grant == '0) begin
          check("grant_expected", exp_grant_q.size() != 0, 1'b1);
          if (exp_grant_q.size() != 0) begin
            g = exp_grant_q.pop_front();
            check("grant", bus.grant, NUM_SRC'(1) << g);
            check("busy", bus.busy, 1'b1);
          end
        end
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_beat  = {bus.m_tdata, bus.m_tkeep, bus.m_tlast};
      end else begin
        prev_stall = 1'b0;
      end
      prev_grant = bus.grant;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before it", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  waited;
    beat_t b;

    // 1) reset with requests pending; sources 0 and 2 race, 0 must win first
    ready_mode = 1;
    repeat (2) @(negedge aclk);
    add_packet(0, 1, 1'b0);
    add_packet(2, 1, 1'b0);
    commit();
    repeat (2) @(negedge aclk);
    check("rst_s_tvalid_driven", bus.s_tvalid, 4'b0101);
    check("rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("rst_m_tdata", bus.m_tdata, '0);
    check("rst_m_tkeep", bus.m_tkeep, '0);
    check("rst_m_tlast", bus.m_tlast, 1'b0);
    check("rst_grant", bus.grant, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_s_tready", bus.s_tready, '0);
    aresetn = 1'b1;
    wait_drain("t1", 200);

    // 2) four 2-beat bursts, always-ready packer: order 0..3, one bubble between bursts
    do_reset();
    gap_en = 1'b0;
    out_cyc.delete();
    for (int k = 0; k < NUM_SRC; k++) add_packet(k, 2, 1'b0);
    commit();
    wait_drain("t2", 200);
    check("t2_beat_count", out_cyc.size(), 8);
    for (int i = 0; i + 1 < out_cyc.size(); i++)
      check("t2_beat_spacing", out_cyc[i+1] - out_cyc[i], (i % 2 == 0) ? 1 : 2);

    // 3) long stream from source 1 is cut at MAX_BEATS and source 2 gets in between
    @(negedge aclk);
    add_packet(1, 40, 1'b0);
    add_packet(2, 3, 1'b0);
    commit();
    wait_drain("t3", 400);

    // 4) packer ready pattern 1,0,0,1 with source valid gaps
    ready_mode = 3;
    gap_en     = 1'b1;
    @(negedge aclk);
    add_packet(0, 8, 1'b0);
    add_packet(3, 8, 1'b0);
    commit();
    wait_drain("t4", 400);

    // 5) empty beats: swallowed and counted unless final
    ready_mode = 0;
    gap_en     = 1'b0;
    @(negedge aclk);
    b = rand_beat(1'b0, 1'b0);              stage[0].push_back(b);
    b.keep = '0;                            stage[0].push_back(b);
    b = rand_beat(1'b0, 1'b0); b.keep = 1;  stage[0].push_back(b);
    b = rand_beat(1'b0, 1'b1); b.keep = '0; stage[0].push_back(b);
    for (int j = 0; j < 15; j++) stage[1].push_back(rand_beat(1'b0, 1'b0));
    b = rand_beat(1'b0, 1'b0); b.keep = '0; stage[1].push_back(b);
    add_packet(1, 2, 1'b0);
    add_packet(3, 2, 1'b0);
    commit();
    wait_drain("t5", 400);

    // 6) reset mid-burst while the output register holds a beat
    ready_mode = 2;
    @(negedge aclk);
    add_packet(2, 6, 1'b0);
    commit();
    waited = 0;
    while (!bus.m_tvalid && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    check("t6_m_tvalid_before_reset", bus.m_tvalid, 1'b1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("t6_m_tvalid_after_reset", bus.m_tvalid, 1'b0);
    check("t6_grant_after_reset", bus.grant, '0);
    check("t6_busy_after_reset", bus.busy, 1'b0);
    flush_model();
    add_packet(3, 2, 1'b0);
    add_packet(1, 2, 1'b0);
    commit();
    @(negedge aclk);
    aresetn    = 1'b1;
    ready_mode = 0;
    wait_drain("t6", 200);

    // Randomized phases: random bursts, empty beats, valid gaps, random backpressure
    gap_en = 1'b1;
    for (int ph = 0; ph < 8; ph++) begin
      @(negedge aclk);
      for (int k = 0; k < NUM_SRC; k++)
        if ($urandom_range(3) != 0)
          for (int p = 0; p < int'($urandom_range(1, 3)); p++)
            add_packet(k, int'($urandom_range(1, 20)), 1'b1);
      commit();
      wait_drain("rand", 3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
